// File: rtl/data_ram_wait_pkg.sv
// Shared types for the MEM-stage data RAM with wait states.
// Default-configuration address/data/byte-enable types and FSM states.
package data_ram_wait_pkg;

   localparam int RAM_MAX_WAIT = 15;

   typedef logic [31:0] ram_addr_t;
   typedef logic [31:0] ram_data_t;
   typedef logic [3:0]  ram_sel_t;

   typedef enum logic [1:0] {
      RAM_IDLE,
      RAM_WAIT,
      RAM_RESP
   } ram_state_t;

   typedef enum logic {
      CHIP_DISABLE = 1'b0,
      CHIP_ENABLE  = 1'b1
   } chip_en_t;

endpackage

// File: rtl/data_ram_wait_byte_bank.sv
// One byte lane of the data RAM: single-port array, registered read.
// Maps to block RAM.
module byte_bank #(
   parameter int DEPTH = 131072,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i)
            mem_q[addr_i] <= wdata_i;
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_wait.sv
// Banked data RAM with req/ack handshake, wait states and range fault.
// Banks are accessed on the edge that enters RESP, using next-state copies.
module data_ram_wait
   import data_ram_wait_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 131072,
   parameter int WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  chip_en_t            ce,
   input  logic                req,
   input  logic                we,
   input  logic [DATA_W/8-1:0] sel,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data_i,
   output logic [DATA_W-1:0]   data_o,
   output logic                ack,
   output logic                busy,
   output logic                fault
);

   localparam int NB   = DATA_W / 8;
   localparam int OFFS = $clog2(NB);
   localparam int AW   = $clog2(DEPTH_WORDS);
   localparam int CW   = $clog2(RAM_MAX_WAIT + 1);

   typedef logic [CW-1:0] cnt_t;

   ram_state_t          state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [NB-1:0]       sel_q, sel_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                oor_q, oor_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0]   rdata;
   logic [DATA_W-1:0]   rd_val;
   logic [ADDR_W-1:0]   widx;
   logic                bank_en;

   assign widx = addr >> OFFS;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      oor_d   = oor_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      rd_val  = hold_q;
      unique case (state_q)
         RAM_IDLE: begin
            if (req && ce == CHIP_ENABLE) begin
               we_d    = we;
               sel_d   = sel;
               idx_d   = widx[AW-1:0];
               oor_d   = (widx >> AW) != '0;
               wdata_d = data_i;
               if (WAIT_STATES > 0) begin
                  state_d = RAM_WAIT;
                  cnt_d   = cnt_t'(WAIT_STATES - 1);
               end else begin
                  state_d = RAM_RESP;
               end
            end
         end
         RAM_WAIT: begin
            if (cnt_q == '0)
               state_d = RAM_RESP;
            else
               cnt_d = cnt_q - cnt_t'(1);
         end
         RAM_RESP: begin
            state_d = RAM_IDLE;
            rd_val  = (we_q || oor_q) ? '0 : rdata;
            hold_d  = rd_val;
         end
         default: state_d = RAM_IDLE;
      endcase
      // reset wins over a pending bank access
      bank_en = (state_d == RAM_RESP) && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RAM_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
   end

   for (genvar i = 0; i < NB; i++) begin : g_bank
      byte_bank #(
         .DEPTH (DEPTH_WORDS)
      ) u_bank (
         .clk     (clk),
         .en_i    (bank_en),
         .we_i    (we_d & sel_d[i] & ~oor_d),
         .addr_i  (idx_d),
         .wdata_i (wdata_d[8*i +: 8]),
         .rdata_o (rdata[8*i +: 8])
      );
   end

   assign data_o = rd_val;
   assign ack    = (state_q == RAM_RESP);
   assign busy   = (state_q != RAM_IDLE);
   assign fault  = ack && oor_q;

endmodule

// File: tb/tb_data_ram_wait.sv
// Directed bench for data_ram_wait: three instances (0, 3, 5 wait states)
// share one stimulus bus; each section resets and drives one of them.
module tb_data_ram_wait;
   import data_ram_wait_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   chip_en_t    ce;
   logic        req, we;
   logic [3:0]  sel;
   logic [31:0] addr, wdat;
   logic [31:0] do0, do1, do2;
   logic        ack0, ack1, ack2;
   logic        busy0, busy1, busy2;
   logic        flt0, flt1, flt2;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   data_ram_wait #(.WAIT_STATES(0), .DEPTH_WORDS(1024)) u0 (
      .clk(clk), .rst(rst), .ce(ce), .req(req), .we(we), .sel(sel),
      .addr(addr), .data_i(wdat), .data_o(do0), .ack(ack0),
      .busy(busy0), .fault(flt0));

   data_ram_wait #(.WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst), .ce(ce), .req(req), .we(we), .sel(sel),
      .addr(addr), .data_i(wdat), .data_o(do1), .ack(ack1),
      .busy(busy1), .fault(flt1));

   data_ram_wait #(.WAIT_STATES(5)) u5 (
      .clk(clk), .rst(rst), .ce(ce), .req(req), .we(we), .sel(sel),
      .addr(addr), .data_i(wdat), .data_o(do2), .ack(ack2),
      .busy(busy2), .fault(flt2));

   function automatic logic ack_of(input int d);
      case (d)
         0:       return ack0;
         1:       return ack1;
         default: return ack2;
      endcase
   endfunction

   function automatic logic [31:0] do_of(input int d);
      case (d)
         0:       return do0;
         1:       return do1;
         default: return do2;
      endcase
   endfunction

   function automatic logic flt_of(input int d);
      case (d)
         0:       return flt0;
         1:       return flt1;
         default: return flt2;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one access; lat = cycles from acceptance edge to ack (40 = timed out)
   task automatic acc(input int d, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd,
                      output logic f);
      we   = w;
      sel  = s;
      addr = a;
      wdat = wd;
      req  = 1'b1;
      tick();
      req = 1'b0;
      lat = 1;
      while (!ack_of(d) && lat < 40) begin
         tick();
         lat++;
      end
      rd = do_of(d);
      f  = flt_of(d);
      tick();
   endtask

   task automatic reset_all;
      rst = 1'b1;
      req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int          lat;
      int          cnt;
      logic [31:0] rd;
      logic        f;

      ce   = CHIP_ENABLE;
      req  = 1'b0;
      we   = 1'b0;
      sel  = '0;
      addr = '0;
      wdat = '0;
      rst  = 1'b1;
      tick();
      tick();
      chk("rst_data", do0, 32'h0);
      chk("rst_ack", 32'(ack0), 32'h0);
      chk("rst_busy", 32'(busy0), 32'h0);
      chk("rst_fault", 32'(flt0), 32'h0);
      rst = 1'b0;

      acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, f);
      chk("t1_wr_lat", 32'(lat), 32'd1);
      chk("t1_wr_data", rd, 32'h0);
      chk("t1_wr_fault", 32'(f), 32'h0);
      acc(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, f);
      chk("t1_rd_lat", 32'(lat), 32'd1);
      chk("t1_rd_data", rd, 32'hDEADBEEF);
      chk("t1_rd_fault", 32'(f), 32'h0);

      acc(0, 1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, f);
      acc(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, f);
      acc(0, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, f);
      chk("t2_lanes", rd, 32'h11BB33DD);
      acc(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, lat, rd, f);
      chk("t2_sel0_lat", 32'(lat), 32'd1);
      acc(0, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, f);
      chk("t2_sel0_keep", rd, 32'h11BB33DD);

      acc(0, 1'b1, 4'hF, 32'h0, 32'h01020304, lat, rd, f);
      acc(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, lat, rd, f);
      chk("t4_oor_lat", 32'(lat), 32'd1);
      chk("t4_oor_fault", 32'(f), 32'h1);
      chk("t4_oor_data", rd, 32'h0);
      acc(0, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, f);
      chk("t4_w0_data", rd, 32'h01020304);
      chk("t4_w0_fault", 32'(f), 32'h0);

      acc(0, 1'b1, 4'hF, 32'h14, 32'h5A5A1234, lat, rd, f);
      we   = 1'b0;
      addr = 32'h10;
      req  = 1'b1;
      tick();
      chk("t6_ack_a", 32'(ack0), 32'h1);
      chk("t6_data_a", do0, 32'hDEADBEEF);
      addr = 32'h14;
      tick();
      chk("t6_gap_ack", 32'(ack0), 32'h0);
      chk("t6_hold", do0, 32'hDEADBEEF);
      tick();
      chk("t6_ack_b", 32'(ack0), 32'h1);
      chk("t6_data_b", do0, 32'h5A5A1234);
      req = 1'b0;
      tick();
      chk("t6_end_ack", 32'(ack0), 32'h0);

      reset_all();
      acc(1, 1'b1, 4'hF, 32'h30, 32'h12345678, lat, rd, f);
      chk("t3_wr_lat", 32'(lat), 32'd4);
      we   = 1'b0;
      addr = 32'h30;
      req  = 1'b1;
      tick();
      req  = 1'b0;
      addr = 32'h10;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("t3_busy_w%0d", i), 32'(busy1), 32'h1);
         chk($sformatf("t3_ack_w%0d", i), 32'(ack1), 32'h0);
         tick();
      end
      chk("t3_busy_r", 32'(busy1), 32'h1);
      chk("t3_ack_r", 32'(ack1), 32'h1);
      chk("t3_data", do1, 32'h12345678);
      tick();
      chk("t3_idle_busy", 32'(busy1), 32'h0);
      chk("t3_idle_ack", 32'(ack1), 32'h0);

      reset_all();
      acc(2, 1'b1, 4'hF, 32'h40, 32'h0BADBEEF, lat, rd, f);
      chk("t5_wr_lat", 32'(lat), 32'd6);
      we   = 1'b1;
      sel  = 4'hF;
      addr = 32'h40;
      wdat = 32'hCAFEF00D;
      req  = 1'b1;
      tick();
      req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("t5_rst_busy", 32'(busy2), 32'h0);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (ack2) cnt++;
         tick();
      end
      chk("t5_no_ack", 32'(cnt), 32'h0);
      acc(2, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, f);
      chk("t5_rd_lat", 32'(lat), 32'd6);
      chk("t5_old_data", rd, 32'h0BADBEEF);

      ce   = CHIP_DISABLE;
      we   = 1'b0;
      req  = 1'b1;
      cnt  = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (busy2 || ack2) cnt++;
      end
      chk("t5_ce_off", 32'(cnt), 32'h0);
      req = 1'b0;
      ce  = CHIP_ENABLE;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
